tick_prescaler: RTL



---
 rtl/tick_prescaler_pkg.sv | 11 +
 rtl/tick_prescaler_sync.sv | 24 ++
 rtl/tick_prescaler.sv | 58 +++++
 3 files changed

// File: rtl/tick_prescaler_pkg.sv
// tick_prescaler_pkg: shared rate encodings and divider-width helper for tick_prescaler
package tick_prescaler_pkg;
  localparam int TAP_STEP_DEF = 4;
  localparam logic [1:0] RATE_16  = 2'd0;
  localparam logic [1:0] RATE_256 = 2'd1;
  localparam logic [1:0] RATE_4K  = 2'd2;
  localparam logic [1:0] RATE_64K = 2'd3;
  function automatic int rate_n(input logic [1:0] rate, input int tap);
    return tap * (int'(rate) + 1);
  endfunction
endpackage

// File: rtl/tick_prescaler_sync.sv
// sync_vec: W-bit, STAGES-deep input synchroniser, async active-low reset to 0
// ports: clk, rst_n, d (async input bundle), q (synchronised bundle)
module sync_vec #(
  parameter int W = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] ff [STAGES];
  if (STAGES < 2) begin : g_bad_stages
    $error("sync_vec: STAGES must be >= 2");
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < STAGES; i++) ff[i] <= '0;
    else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  assign q = ff[STAGES-1];
endmodule

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running counter producing a single-cycle tick enable at a selectable rate
// ports: clk, rst_n (async active-low); rate_sel/bypass/pause/step (async pins);
//        tick (registered enable), rate_act/bypass_act (config in effect), cnt (observation)
module tick_prescaler import tick_prescaler_pkg::*; #(
  parameter int CNT_W = 16,
  parameter int TAP_STEP = TAP_STEP_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       rate_sel,
  input  logic             bypass,
  input  logic             pause,
  input  logic             step,
  output logic             tick,
  output logic [1:0]       rate_act,
  output logic             bypass_act,
  output logic [CNT_W-1:0] cnt
);
  logic [4:0] in_s;
  logic [1:0] rate_s;
  logic bypass_s, pause_s, step_s, step_prev, term;
  logic [CNT_W-1:0] mask;
  if (CNT_W < TAP_STEP * 4) begin : g_bad_width
    $error("tick_prescaler: CNT_W must be >= TAP_STEP*4");
  end
  sync_vec #(.W(5), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .d({step, pause, bypass, rate_sel}),
    .q(in_s)
  );
  assign {step_s, pause_s, bypass_s, rate_s} = in_s;
  // low N bits set; shifting by the full width yields zero, so N == CNT_W gives all ones
  assign mask = ~({CNT_W{1'b1}} << rate_n(rate_act, TAP_STEP));
  assign term = (cnt & mask) == mask;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt        <= '0;
      tick       <= 1'b0;
      rate_act   <= RATE_16;
      bypass_act <= 1'b0;
      step_prev  <= 1'b0;
    end else begin
      step_prev <= step_s;
      if ({bypass_s, rate_s} != {bypass_act, rate_act}) begin
        rate_act   <= rate_s;
        bypass_act <= bypass_s;
        cnt        <= '0;
        tick       <= 1'b0;
      end else if (pause_s)
        tick <= step_s & ~step_prev;
      else begin
        tick <= bypass_act | term;
        cnt  <= cnt + 1'b1;
      end
    end
endmodule
